// File: rtl/hazard_ctrl_pkg.sv
// Shared constants for the pipeline hazard controller: FSM encoding, the
// hard-wired zero register and the default data-memory timeout.
package hazard_ctrl_pkg;

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_MEM_WAIT = 2'd1;
    localparam logic [1:0] ST_ERROR    = 2'd2;

    localparam logic [4:0] REG_ZERO        = 5'd0;
    localparam int         MEM_TIMEOUT_DEF = 200;

endpackage

// File: rtl/hazard_lu_detect.sv
// Combinational load-use detector: a load in EX whose destination is read by
// the instruction in ID. Register $0 is never a hazard.
module hazard_lu_detect
    import hazard_ctrl_pkg::*;
(
    input  logic       memread,
    input  logic [4:0] ex_rt,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    output logic       hazard
);

    assign hazard = memread && (ex_rt != REG_ZERO) &&
                    ((ex_rt == id_rs) || (ex_rt == id_rt));

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard/stall controller for the 5-stage core: load-use bubbles, branch/jump
// flushes and the data-memory req/ack freeze with a sticky timeout.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
    parameter int TO_W        = 8,
    parameter int PERF_W      = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              IDEX_memread_i,
    input  logic [4:0]        IDEX_rt_i,
    input  logic [4:0]        IFID_rs_i,
    input  logic [4:0]        IFID_rt_i,
    input  logic              branch_taken_i,
    input  logic              jump_i,
    input  logic              EXMEM_memreq_i,
    input  logic              dmem_ack_i,
    output logic              dmem_req_o,
    output logic              PC_write_o,
    output logic              IFID_write_o,
    output logic              IFID_flush_o,
    output logic              IDEX_bubble_o,
    output logic              pipe_hold_o,
    output logic              err_o
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [PERF_W-1:0] lu_stall_cnt_o,
    output logic [PERF_W-1:0] mem_stall_cnt_o,
    output logic [PERF_W-1:0] flush_cnt_o
`endif
);

    logic [1:0]      state_q, state_d;
    logic [TO_W-1:0] wait_q, wait_d;
    logic            req;
    logic            mem_stall;
    logic            lu_hazard;
    logic            lu_bubble;
    logic            do_flush;

    hazard_lu_detect u_lu_detect (
        .memread (IDEX_memread_i),
        .ex_rt   (IDEX_rt_i),
        .id_rs   (IFID_rs_i),
        .id_rt   (IFID_rt_i),
        .hazard  (lu_hazard)
    );

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        req       = 1'b0;
        mem_stall = 1'b0;
        case (state_q)
            ST_RUN: begin
                req = EXMEM_memreq_i;
                if (EXMEM_memreq_i && !dmem_ack_i) begin
                    mem_stall = 1'b1;
                    state_d   = ST_MEM_WAIT;
                    wait_d    = TO_W'(1);
                end
            end
            ST_MEM_WAIT: begin
                req = 1'b1;
                if (dmem_ack_i) begin
                    state_d = ST_RUN;
                    wait_d  = '0;
                end else begin
                    mem_stall = 1'b1;
                    if (wait_q == TO_W'(MEM_TIMEOUT)) state_d = ST_ERROR;
                    else                              wait_d  = wait_q + TO_W'(1);
                end
            end
            ST_ERROR: mem_stall = 1'b1;
            default: begin
                state_d = ST_RUN;
                wait_d  = '0;
            end
        endcase
    end

    // Memory stall outranks load-use, which in turn suppresses the flush.
    assign lu_bubble = !mem_stall && lu_hazard;
    assign do_flush  = !mem_stall && !lu_hazard && (branch_taken_i || jump_i);

    // While reset is held the pipeline free-runs and the memory request is dropped.
    assign dmem_req_o    = rst_i && req;
    assign PC_write_o    = !rst_i || (!mem_stall && !lu_hazard);
    assign IFID_write_o  = !rst_i || (!mem_stall && !lu_hazard);
    assign IFID_flush_o  = rst_i && do_flush;
    assign IDEX_bubble_o = rst_i && lu_bubble;
    assign pipe_hold_o   = rst_i && mem_stall;
    assign err_o         = rst_i && (state_q == ST_ERROR);

    // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_RUN;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            lu_stall_cnt_o  <= '0;
            mem_stall_cnt_o <= '0;
            flush_cnt_o     <= '0;
        end else begin
            if (lu_bubble && !(&lu_stall_cnt_o))  lu_stall_cnt_o  <= lu_stall_cnt_o + PERF_W'(1);
            if (mem_stall && !(&mem_stall_cnt_o)) mem_stall_cnt_o <= mem_stall_cnt_o + PERF_W'(1);
            if (do_flush && !(&flush_cnt_o))      flush_cnt_o     <= flush_cnt_o + PERF_W'(1);
        end
    end
`else
    // Counter width only matters when the counters are built.
    logic unused_perf_w;
    assign unused_perf_w = (PERF_W > 0);
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus a randomized
// run against a cycle-level reference model of the stall/flush rules.
module tb_hazard_ctrl;

    localparam int TO = 5;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       IDEX_memread_i;
    logic [4:0] IDEX_rt_i, IFID_rs_i, IFID_rt_i;
    logic       branch_taken_i, jump_i, EXMEM_memreq_i, dmem_ack_i;
    logic       dmem_req_o, PC_write_o, IFID_write_o, IFID_flush_o;
    logic       IDEX_bubble_o, pipe_hold_o, err_o;

    int checks = 0;
    int errors = 0;

    hazard_ctrl #(.MEM_TIMEOUT(TO)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .IDEX_memread_i (IDEX_memread_i),
        .IDEX_rt_i      (IDEX_rt_i),
        .IFID_rs_i      (IFID_rs_i),
        .IFID_rt_i      (IFID_rt_i),
        .branch_taken_i (branch_taken_i),
        .jump_i         (jump_i),
        .EXMEM_memreq_i (EXMEM_memreq_i),
        .dmem_ack_i     (dmem_ack_i),
        .dmem_req_o     (dmem_req_o),
        .PC_write_o     (PC_write_o),
        .IFID_write_o   (IFID_write_o),
        .IFID_flush_o   (IFID_flush_o),
        .IDEX_bubble_o  (IDEX_bubble_o),
        .pipe_hold_o    (pipe_hold_o),
        .err_o          (err_o)
    );

    always #5 clk_i = ~clk_i;

    // Output vector order: {req, pc_wr, ifid_wr, flush, bubble, hold, err}
    localparam logic [6:0] V_IDLE  = 7'b0110000;
    localparam logic [6:0] V_LU    = 7'b0000100;
    localparam logic [6:0] V_FLUSH = 7'b0111000;
    localparam logic [6:0] V_MSTL  = 7'b1000010;
    localparam logic [6:0] V_ZW    = 7'b1110000;
    localparam logic [6:0] V_REL_F = 7'b1111000;
    localparam logic [6:0] V_ERR   = 7'b0000011;

    logic [6:0] obs;
    assign obs = {dmem_req_o, PC_write_o, IFID_write_o, IFID_flush_o,
                  IDEX_bubble_o, pipe_hold_o, err_o};

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_in(input logic mr, input logic [4:0] ert, input logic [4:0] rs,
                          input logic [4:0] rt, input logic br, input logic j,
                          input logic mq, input logic ack);
        IDEX_memread_i = mr;
        IDEX_rt_i      = ert;
        IFID_rs_i      = rs;
        IFID_rt_i      = rt;
        branch_taken_i = br;
        jump_i         = j;
        EXMEM_memreq_i = mq;
        dmem_ack_i     = ack;
    endtask

    task automatic test_reset();
        rst_i = 1'b0;
        set_in(1'b1, 5'd3, 5'd3, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0);
        #3;
        checks++;
        if (obs !== V_IDLE) begin
            errors++;
            $display("FAIL reset_outputs got=%b want=%b", obs, V_IDLE);
        end
        step();
        step();
        set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_i = 1'b1;
        #2;
        checks++;
        if (obs !== V_IDLE) begin
            errors++;
            $display("FAIL idle_after_reset got=%b want=%b", obs, V_IDLE);
        end
    endtask

    task automatic test_load_use();
        step();
        set_in(1'b1, 5'd8, 5'd8, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        #2;
        checks++;
        if (obs !== V_LU) begin
            errors++;
            $display("FAIL lu_rs got=%b want=%b", obs, V_LU);
        end
        step();
        set_in(1'b0, 5'd0, 5'd8, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        #2;
        checks++;
        if (obs !== V_IDLE) begin
            errors++;
            $display("FAIL lu_cleared got=%b want=%b", obs, V_IDLE);
        end
        step();
        set_in(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        #2;
        checks++;
        if (obs !== V_IDLE) begin
            errors++;
            $display("FAIL lu_reg_zero got=%b want=%b", obs, V_IDLE);
        end
        step();
        set_in(1'b1, 5'd17, 5'd2, 5'd17, 1'b0, 1'b0, 1'b0, 1'b0);
        #2;
        checks++;
        if (obs !== V_LU) begin
            errors++;
            $display("FAIL lu_rt got=%b want=%b", obs, V_LU);
        end
        step();
        set_in(1'b1, 5'd17, 5'd2, 5'd16, 1'b0, 1'b0, 1'b0, 1'b0);
        #2;
        checks++;
        if (obs !== V_IDLE) begin
            errors++;
            $display("FAIL lu_no_match got=%b want=%b", obs, V_IDLE);
        end
    endtask

    task automatic test_branch();
        step();
        set_in(1'b0, 5'd0, 5'd4, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        #2;
        checks++;
        if (obs !== V_FLUSH) begin
            errors++;
            $display("FAIL branch_flush got=%b want=%b", obs, V_FLUSH);
        end
        step();
        set_in(1'b0, 5'd0, 5'd4, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0);
        #2;
        checks++;
        if (obs !== V_FLUSH) begin
            errors++;
            $display("FAIL jump_flush got=%b want=%b", obs, V_FLUSH);
        end
        step();
        set_in(1'b1, 5'd9, 5'd4, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
        #2;
        checks++;
        if (obs !== V_LU) begin
            errors++;
            $display("FAIL branch_vs_lu got=%b want=%b", obs, V_LU);
        end
    endtask

    task automatic test_zero_wait();
        step();
        set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        #2;
        checks++;
        if (obs !== V_ZW) begin
            errors++;
            $display("FAIL zero_wait got=%b want=%b", obs, V_ZW);
        end
        step();
        set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        #2;
        checks++;
        if (obs !== V_IDLE) begin
            errors++;
            $display("FAIL zero_wait_run got=%b want=%b", obs, V_IDLE);
        end
    endtask

    task automatic test_multi_wait();
        for (int c = 0; c < 3; c++) begin
            step();
            set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0);
            #2;
            checks++;
            if (obs !== V_MSTL) begin
                errors++;
                $display("FAIL mem_wait_c%0d got=%b want=%b", c, obs, V_MSTL);
            end
        end
        step();
        set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1);
        #2;
        checks++;
        if (obs !== V_REL_F) begin
            errors++;
            $display("FAIL mem_release got=%b want=%b", obs, V_REL_F);
        end
        step();
        set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        #2;
        checks++;
        if (obs !== V_IDLE) begin
            errors++;
            $display("FAIL mem_back_to_run got=%b want=%b", obs, V_IDLE);
        end
    endtask

    task automatic test_timeout();
        // One RUN stall cycle plus TO cycles in MEM_WAIT before the error.
        for (int c = 0; c <= TO; c++) begin
            step();
            set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
            #2;
            checks++;
            if (obs !== V_MSTL) begin
                errors++;
                $display("FAIL timeout_wait_c%0d got=%b want=%b", c, obs, V_MSTL);
            end
        end
        step();
        #2;
        checks++;
        if (obs !== V_ERR) begin
            errors++;
            $display("FAIL timeout_error got=%b want=%b", obs, V_ERR);
        end
        step();
        set_in(1'b1, 5'd6, 5'd6, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1);
        #2;
        checks++;
        if (obs !== V_ERR) begin
            errors++;
            $display("FAIL error_late_ack got=%b want=%b", obs, V_ERR);
        end
        step();
        set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        #2;
        rst_i = 1'b0;
        #1;
        checks++;
        if (obs !== V_IDLE) begin
            errors++;
            $display("FAIL async_reset got=%b want=%b", obs, V_IDLE);
        end
        step();
        rst_i = 1'b1;
        #2;
        checks++;
        if (obs !== V_IDLE) begin
            errors++;
            $display("FAIL run_after_error got=%b want=%b", obs, V_IDLE);
        end
    endtask

    // Expected outputs from the stall/flush rules given the model's memory status.
    function automatic logic [6:0] model_out(input bit in_rst, input bit busy, input bit failed);
        bit lu, mstall, req, br;
        if (in_rst) return V_IDLE;
        lu     = IDEX_memread_i && (IDEX_rt_i != 0) &&
                 (IDEX_rt_i == IFID_rs_i || IDEX_rt_i == IFID_rt_i);
        br     = branch_taken_i || jump_i;
        mstall = failed || (!dmem_ack_i && (busy || EXMEM_memreq_i));
        req    = !failed && (busy || EXMEM_memreq_i);
        return {req, !mstall && !lu, !mstall && !lu, !mstall && !lu && br,
                !mstall && lu, mstall, failed};
    endfunction

    task automatic test_random(input int n);
        bit         busy = 0, failed = 0, hold_rst = 0;
        int         waited = 0;
        logic [6:0] exp;
        for (int i = 0; i < n; i++) begin
            step();
            rst_i = 1'b1;
            set_in($urandom_range(0, 1) == 1, 5'($urandom_range(0, 3)),
                   5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
                   $urandom_range(0, 1) == 1, $urandom_range(0, 9) < 4);
            hold_rst = failed && ($urandom_range(0, 2) == 0);
            if (hold_rst) rst_i = 1'b0;
            #2;
            exp = model_out(hold_rst, busy, failed);
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL random_c%0d got=%b want=%b", i, obs, exp);
            end
            if (hold_rst) begin
                busy = 0; failed = 0; waited = 0;
            end else if (!failed) begin
                if (busy) begin
                    if (dmem_ack_i) begin
                        busy = 0; waited = 0;
                    end else if (waited == TO) begin
                        failed = 1;
                    end else begin
                        waited++;
                    end
                end else if (EXMEM_memreq_i && !dmem_ack_i) begin
                    busy = 1; waited = 1;
                end
            end
        end
        step();
        rst_i = 1'b1;
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch();
        test_zero_wait();
        test_multi_wait();
        test_timeout();
        test_random(800);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
